// File: rtl/rv4028_bus_arbiter.sv
// Two-port arbiter for the RV4028 16-bit external bus: grants one 32-bit requester,
// splits word accesses into low/high beats, honours wait states and reports timeouts.
module rv4028_bus_arbiter #(
    parameter int          PRIO_FIXED = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic        req0_half,
    input  logic [31:0] req0_addr,
    input  logic [3:0]  req0_mask,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic        req1_half,
    input  logic [31:0] req1_addr,
    input  logic [3:0]  req1_mask,
    input  logic [31:0] req1_wdata,
    output logic        ack0,
    output logic        err0,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata,
    output logic [1:0]  gnt,
    output logic [31:0] bus_addr,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    output logic [1:0]  bus_msk_n,
    output logic        bus_mreq_n,
    output logic        bus_iorq_n,
    input  logic        bus_wait_n,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    output logic        bus_oe
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state, state_n;
    logic        owner, rr_prio, err_q, sel, beat_done, abort, in_beat, beat_a1, timeout_hit;
    logic [31:0] wait_cnt;
    logic        lat_we, lat_half;
    logic [31:1] lat_addr;
    logic [3:0]  lat_mask;
    logic [31:0] lat_wdata;
    logic [15:0] d0, d1;
    logic        unused_addr0;

    assign unused_addr0 = ^{req0_addr[0], req1_addr[0]};

    assign in_beat     = (state == BEAT0) || (state == BEAT1);
    assign beat_a1     = (state == BEAT1) || (lat_half && lat_addr[1]);
    assign timeout_hit = (TIMEOUT != 0) && ((wait_cnt + 32'd1) >= TIMEOUT);

    always_comb begin
        state_n   = state;
        beat_done = 1'b0;
        abort     = 1'b0;
        // sel: 0 = port 0, 1 = port 1; rr_prio names the port favoured on a tie
        if (PRIO_FIXED != 0)
            sel = !req0_valid;
        else if (req0_valid && req1_valid)
            sel = rr_prio;
        else
            sel = req1_valid;
        case (state)
            IDLE: if (req0_valid || req1_valid) state_n = BEAT0;
            BEAT0, BEAT1: begin
                if (bus_wait_n) begin
                    beat_done = 1'b1;
                    state_n   = (state == BEAT0 && !lat_half) ? BEAT1 : RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_prio  <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && (req0_valid || req1_valid)) begin
                owner    <= sel;
                rr_prio  <= !sel;
                err_q    <= 1'b0;
                wait_cnt <= '0;
            end
            if (in_beat) begin
                wait_cnt <= (bus_wait_n || abort) ? '0 : wait_cnt + 32'd1;
                if (abort) err_q <= 1'b1;
            end
        end
    end

    // Request capture and read-data halves carry no reset; they are only consumed after a grant
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            lat_we    <= sel ? req1_we    : req0_we;
            lat_half  <= sel ? req1_half  : req0_half;
            lat_addr  <= sel ? req1_addr[31:1] : req0_addr[31:1];
            lat_mask  <= sel ? req1_mask  : req0_mask;
            lat_wdata <= sel ? req1_wdata : req0_wdata;
        end
        if (beat_done && !lat_we) begin
            if (state == BEAT0) d0 <= bus_din;
            else                d1 <= bus_din;
        end
    end

    always_comb begin
        gnt        = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
        ack0       = (state == RESP) && !owner;
        ack1       = (state == RESP) && owner;
        err0       = ack0 && err_q;
        err1       = ack1 && err_q;
        rdata      = '0;
        if (state == RESP && !err_q && !lat_we)
            rdata = lat_half ? {d0, d0} : {d1, d0};
        bus_addr   = in_beat ? {lat_addr[31:2], beat_a1, 1'b0} : 32'd0;
        bus_rd_n   = !(in_beat && !lat_we);
        bus_wr_n   = !(in_beat && lat_we);
        bus_mreq_n = !in_beat;
        bus_iorq_n = !(in_beat && lat_addr[31]);
        bus_oe     = in_beat && lat_we;
        bus_msk_n  = in_beat ? ~(beat_a1 ? lat_mask[3:2] : lat_mask[1:0]) : 2'b11;
        bus_dout   = (in_beat && lat_we) ? (beat_a1 ? lat_wdata[31:16] : lat_wdata[15:0]) : 16'd0;
    end
endmodule

// File: tb/tb_rv4028_bus_arbiter.sv
// Directed bench for rv4028_bus_arbiter: cycle table for basic transfers plus
// hand sequences for arbitration, timeout and mid-beat reset.
module tb_rv4028_bus_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic v0 = 0, we0 = 0, h0 = 0, v1 = 0, we1 = 0, h1 = 0;
    logic [31:0] ad0 = 0, wd0 = 0, ad1 = 0, wd1 = 0;
    logic [3:0]  mk0 = 0, mk1 = 0;
    logic        wt = 1'b1;
    logic [15:0] din = 0;

    logic a_ack0, a_err0, a_ack1, a_err1, a_rd, a_wr, a_mreq, a_iorq, a_oe;
    logic [31:0] a_rdata, a_addr;
    logic [1:0]  a_gnt, a_msk;
    logic [15:0] a_dout;
    logic b_ack0, b_err0, b_ack1, b_err1, b_rd, b_wr, b_mreq, b_iorq, b_oe;
    logic [31:0] b_rdata, b_addr;
    logic [1:0]  b_gnt, b_msk;
    logic [15:0] b_dout;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rv4028_bus_arbiter #(.PRIO_FIXED(0), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_we(we0), .req0_half(h0), .req0_addr(ad0), .req0_mask(mk0), .req0_wdata(wd0),
        .req1_valid(v1), .req1_we(we1), .req1_half(h1), .req1_addr(ad1), .req1_mask(mk1), .req1_wdata(wd1),
        .ack0(a_ack0), .err0(a_err0), .ack1(a_ack1), .err1(a_err1), .rdata(a_rdata), .gnt(a_gnt),
        .bus_addr(a_addr), .bus_rd_n(a_rd), .bus_wr_n(a_wr), .bus_msk_n(a_msk), .bus_mreq_n(a_mreq),
        .bus_iorq_n(a_iorq), .bus_wait_n(wt), .bus_din(din), .bus_dout(a_dout), .bus_oe(a_oe));

    rv4028_bus_arbiter #(.PRIO_FIXED(1), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_we(we0), .req0_half(h0), .req0_addr(ad0), .req0_mask(mk0), .req0_wdata(wd0),
        .req1_valid(v1), .req1_we(we1), .req1_half(h1), .req1_addr(ad1), .req1_mask(mk1), .req1_wdata(wd1),
        .ack0(b_ack0), .err0(b_err0), .ack1(b_ack1), .err1(b_err1), .rdata(b_rdata), .gnt(b_gnt),
        .bus_addr(b_addr), .bus_rd_n(b_rd), .bus_wr_n(b_wr), .bus_msk_n(b_msk), .bus_mreq_n(b_mreq),
        .bus_iorq_n(b_iorq), .bus_wait_n(wt), .bus_din(din), .bus_dout(b_dout), .bus_oe(b_oe));

    typedef struct {
        logic        rst_n, v0, v1, wt;
        logic [15:0] din;
        logic [1:0]  gnt;
        logic        ack0, ack1, err;
        logic [31:0] rdata, addr;
        logic [3:0]  strb;   // {rd_n, wr_n, mreq_n, iorq_n}
        logic [1:0]  msk;
        logic [15:0] dout;
        logic        oe;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0; v0 = 0; v1 = 0; wt = 1;
        @(negedge clk); rst_n = 1;
    endtask

    logic [127:0] got_v, exp_v;
    int n;
    logic seen;

    initial begin
        // req0: word read at 0x1000; req1: half write at 0x8000_0006
        we0 = 0; h0 = 0; ad0 = 32'h0000_1000; mk0 = 4'hF; wd0 = 32'hCAFE_0000;
        we1 = 1; h1 = 1; ad1 = 32'h8000_0006; mk1 = 4'b1100; wd1 = 32'hBEEF_0000;
        //        rst v0 v1 wt din       gnt   a0 a1 er rdata          addr           strb     msk    dout      oe
        tbl[0]  = '{0, 0, 0, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[1]  = '{1, 1, 0, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[2]  = '{1, 1, 0, 1, 16'h1111, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1000, 4'b0101, 2'b00, 16'h0,    0};
        tbl[3]  = '{1, 1, 0, 1, 16'h2222, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1002, 4'b0101, 2'b00, 16'h0,    0};
        tbl[4]  = '{1, 1, 0, 1, 16'h0,    2'b01, 1, 0, 0, 32'h2222_1111, 32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[5]  = '{1, 0, 0, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[6]  = '{1, 0, 1, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[7]  = '{1, 0, 1, 1, 16'h0,    2'b10, 0, 0, 0, 32'h0,         32'h8000_0006, 4'b1000, 2'b00, 16'hBEEF, 1};
        tbl[8]  = '{1, 0, 1, 1, 16'h0,    2'b10, 0, 1, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[9]  = '{1, 0, 0, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[10] = '{1, 1, 0, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[11] = '{1, 1, 0, 1, 16'h3333, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1000, 4'b0101, 2'b00, 16'h0,    0};
        tbl[12] = '{1, 1, 0, 0, 16'hDEAD, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1002, 4'b0101, 2'b00, 16'h0,    0};
        tbl[13] = '{1, 1, 0, 0, 16'hDEAD, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1002, 4'b0101, 2'b00, 16'h0,    0};
        tbl[14] = '{1, 1, 0, 0, 16'hDEAD, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1002, 4'b0101, 2'b00, 16'h0,    0};
        tbl[15] = '{1, 1, 0, 1, 16'h4444, 2'b01, 0, 0, 0, 32'h0,         32'h0000_1002, 4'b0101, 2'b00, 16'h0,    0};
        tbl[16] = '{1, 1, 0, 1, 16'h0,    2'b01, 1, 0, 0, 32'h4444_3333, 32'h0,         4'b1111, 2'b11, 16'h0,    0};
        tbl[17] = '{1, 0, 0, 1, 16'h0,    2'b00, 0, 0, 0, 32'h0,         32'h0,         4'b1111, 2'b11, 16'h0,    0};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; v0 = tbl[i].v0; v1 = tbl[i].v1; wt = tbl[i].wt; din = tbl[i].din;
            #1;
            got_v = {36'd0, a_gnt, a_ack0, a_ack1, a_err0 | a_err1, a_rdata, a_addr,
                     a_rd, a_wr, a_mreq, a_iorq, a_msk, a_dout, a_oe};
            exp_v = {36'd0, tbl[i].gnt, tbl[i].ack0, tbl[i].ack1, tbl[i].err, tbl[i].rdata, tbl[i].addr,
                     tbl[i].strb, tbl[i].msk, tbl[i].dout, tbl[i].oe};
            chk($sformatf("vec%0d", i), got_v, exp_v);
        end

        // Both ports always requesting: round-robin alternates, fixed priority stays on port 0
        do_reset();
        we0 = 0; h0 = 1; ad0 = 32'h10; we1 = 0; h1 = 1; ad1 = 32'h20;
        v0 = 1; v1 = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (a_gnt == 2'b00 && n < 8);
            chk($sformatf("rr_gnt%0d", k), {126'd0, a_gnt}, {126'd0, (k % 2 == 0) ? 2'b01 : 2'b10});
            chk($sformatf("fixed_gnt%0d", k), {126'd0, b_gnt}, {126'd0, 2'b01});
            n = 0;
            do begin @(negedge clk); n++; end while (a_gnt != 2'b00 && n < 8);
        end
        v0 = 0; v1 = 0;

        // Hung slave: abort after 4 wait cycles, then a normal request completes
        do_reset();
        we0 = 0; h0 = 0; ad0 = 32'h0000_1000; wt = 0; v0 = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_ack0 && n < 12);
        chk("timeout_latency", 128'(n), 128'd5);
        chk("timeout_err_rdata", {95'd0, a_err0, a_rdata}, {95'd0, 1'b1, 32'h0});
        v0 = 0; wt = 1;
        @(negedge clk);
        we1 = 0; h1 = 1; ad1 = 32'h0000_0030; din = 16'h5A5A; v1 = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_ack1 && n < 12);
        chk("after_timeout_latency", 128'(n), 128'd2);
        chk("after_timeout_data", {95'd0, a_err1, a_rdata}, {95'd0, 1'b0, 32'h5A5A_5A5A});
        v1 = 0;

        // Reset while the high beat of a write is on the bus
        do_reset();
        we0 = 1; h0 = 0; ad0 = 32'h0000_2000; mk0 = 4'hF; wd0 = 32'h1234_5678;
        @(negedge clk); v0 = 1;
        @(negedge clk);
        @(negedge clk);
        chk("wr_beat1", {79'd0, a_wr, a_addr, a_dout}, {79'd0, 1'b0, 32'h0000_2002, 16'h1234});
        rst_n = 0;
        @(negedge clk);
        chk("rst_idle", {121'd0, a_rd, a_wr, a_mreq, a_iorq, a_gnt, a_ack0},
            {121'd0, 4'b1111, 2'b00, 1'b0});
        rst_n = 1; v0 = 0;
        seen = 0;
        repeat (6) begin @(negedge clk); seen = seen | a_ack0; end
        chk("no_ack_after_rst", {127'd0, seen}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
